// File: rtl/romload_if.sv
// Bundles the ROM arbiter read port, host loader stream and external memory
// port of romload; the slave modport is the romload side.
interface romload_if #(
  parameter int AW = 22
);
  logic [AW-1:0] romaddr;
  logic          romreq;
  logic [7:0]    romdata;
  logic          romack;
  logic          ldstart;
  logic          ldvalid;
  logic [7:0]    lddata;
  logic          ldlast;
  logic          ldready;
  logic          init;
  logic          lderr;
  logic [AW-1:0] memaddr;
  logic [7:0]    memwdata;
  logic [7:0]    memrdata;
  logic          memoe;
  logic          memwe;

  modport slave (
    input  romaddr, romreq, ldstart, ldvalid, lddata, ldlast, memrdata,
    output romdata, romack, ldready, init, lderr, memaddr, memwdata, memoe, memwe
  );

  modport master (
    output romaddr, romreq, ldstart, ldvalid, lddata, ldlast, memrdata,
    input  romdata, romack, ldready, init, lderr, memaddr, memwdata, memoe, memwe
  );
endinterface

// File: rtl/romload.sv
// Shares one fixed-latency byte-wide ROM memory between host image loading
// (writes) and ROM arbiter reads; holds init high while a load is in progress.
module romload #(
  parameter int LAT = 3,
  parameter int AW  = 22
) (
  input  logic     clk,
  input  logic     rstn,
  romload_if.slave bus
);
  localparam int              CW       = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(LAT - 1);
  localparam logic [AW-1:0]   ADDR_MAX = '1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RDONE} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] waddr_q;
  logic [AW-1:0] memaddr_q;
  logic [7:0]    memwdata_q;
  logic [7:0]    romdata_q;
  logic          romack_q;
  logic          init_q;
  logic          lderr_q;
  logic          memoe_q;
  logic          memwe_q;
  logic          ldlast_q;
  logic          stale_q;  // a restart arrived while this write was in flight

  logic ldready;
  logic accept;
  logic last_cycle;

  // NOTE: ldready is combinational so a same-cycle ldstart can veto acceptance;
  // every other output comes straight from a flop.
  assign ldready    = (state_q == IDLE) && init_q && !bus.ldstart;
  assign accept     = ldready && bus.ldvalid;
  assign last_cycle = (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      waddr_q    <= '0;
      memaddr_q  <= '0;
      memwdata_q <= '0;
      romdata_q  <= '0;
      romack_q   <= 1'b0;
      init_q     <= 1'b0;
      lderr_q    <= 1'b0;
      memoe_q    <= 1'b0;
      memwe_q    <= 1'b0;
      ldlast_q   <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      romack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            memaddr_q  <= waddr_q;
            memwdata_q <= bus.lddata;
            memwe_q    <= !lderr_q;
            ldlast_q   <= bus.ldlast;
            stale_q    <= 1'b0;
            cnt_q      <= '0;
            state_q    <= WRITE;
          end else if (!init_q && bus.romreq && !bus.ldstart) begin
            memaddr_q <= bus.romaddr;
            memoe_q   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= READ;
          end
        end
        READ: begin
          if (last_cycle) begin
            memoe_q   <= 1'b0;
            romdata_q <= bus.memrdata;
            romack_q  <= 1'b1;
            state_q   <= RDONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WRITE: begin
          if (last_cycle) begin
            memwe_q <= 1'b0;
            state_q <= IDLE;
            if (!stale_q) begin
              if (waddr_q == ADDR_MAX) lderr_q <= 1'b1;
              else                     waddr_q <= waddr_q + 1'b1;
              if (ldlast_q) init_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RDONE: begin
          if (!bus.romreq) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // NOTE: placed after the case so these nonblocking writes take priority
      // over any FSM update of the same registers at this edge.
      if (bus.ldstart) begin
        init_q  <= 1'b1;
        waddr_q <= '0;
        lderr_q <= 1'b0;
        stale_q <= 1'b1;
      end
    end
  end

  assign bus.romdata  = romdata_q;
  assign bus.romack   = romack_q;
  assign bus.ldready  = ldready;
  assign bus.init     = init_q;
  assign bus.lderr    = lderr_q;
  assign bus.memaddr  = memaddr_q;
  assign bus.memwdata = memwdata_q;
  assign bus.memoe    = memoe_q;
  assign bus.memwe    = memwe_q;
endmodule

// File: tb/tb_romload.sv
// Scoreboard bench for romload: a 22-bit instance for reads and loads, plus a
// 4-bit-address twin fed the same loader stream to exercise overflow.
module tb_romload;
  localparam int LAT = 3;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  romload_if #(.AW(22)) bus_a ();
  romload_if #(.AW(4))  bus_b ();

  romload #(.LAT(LAT), .AW(22)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a.slave));
  romload #(.LAT(LAT), .AW(4))  dut_b (.clk(clk), .rstn(rstn), .bus(bus_b.slave));

  function automatic logic [7:0] rd_model(input logic [21:0] a);
    return a[7:0] ^ 8'h5E;
  endfunction

  assign bus_a.memrdata = bus_a.memoe ? rd_model(bus_a.memaddr) : 8'h00;
  assign bus_b.memrdata = 8'h00;
  assign bus_b.romreq   = 1'b0;
  assign bus_b.romaddr  = '0;
  assign bus_b.ldstart  = bus_a.ldstart;
  assign bus_b.ldvalid  = bus_a.ldvalid;
  assign bus_b.lddata   = bus_a.lddata;
  assign bus_b.ldlast   = bus_a.ldlast;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int acc_cyc;
  logic [7:0]  exp_rd[$];
  logic [31:0] exp_wr_a[$];
  logic [31:0] exp_wr_b[$];
  logic [21:0] wa_m;
  logic [3:0]  wb_m;
  bit          eb_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitors ----------------
  int oe_a = 0, we_a = 0, we_b = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rstn) begin
      oe_a = 0;
      we_a = 0;
    end else begin
      if (bus_a.memoe) begin
        check("oe_we_excl", 32'(bus_a.memwe), 0);
        check("oe_in_init", 32'(bus_a.init), 0);
        oe_a++;
      end else if (oe_a != 0) begin
        check("oe_len", oe_a, LAT);
        oe_a = 0;
      end
      if (bus_a.memwe) begin
        if (we_a == 0) begin
          if (exp_wr_a.size() > 0) begin
            e = exp_wr_a.pop_front();
            check("wr_addr", 32'(bus_a.memaddr), 32'(e[31:8]));
            check("wr_data", 32'(bus_a.memwdata), 32'(e[7:0]));
          end else check("wr_unexpected", 32'(bus_a.memwe), 0);
        end
        we_a++;
      end else if (we_a != 0) begin
        check("we_len", we_a, LAT);
        we_a = 0;
      end
      if (bus_a.romack) begin
        if (exp_rd.size() > 0) check("romdata", 32'(bus_a.romdata), 32'(exp_rd.pop_front()));
        else                   check("ack_unexpected", 32'(bus_a.romack), 0);
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rstn) begin
      we_b = 0;
    end else begin
      if (bus_b.memoe) check("b_oe_unexpected", 32'(bus_b.memoe), 0);
      if (bus_b.memwe) begin
        if (we_b == 0) begin
          if (exp_wr_b.size() > 0) begin
            e = exp_wr_b.pop_front();
            check("b_wr_addr", 32'(bus_b.memaddr), 32'(e[31:8]));
            check("b_wr_data", 32'(bus_b.memwdata), 32'(e[7:0]));
          end else check("b_wr_unexpected", 32'(bus_b.memwe), 0);
        end
        we_b++;
      end else we_b = 0;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic check_reset_outs();
    check("rst_romack",   32'(bus_a.romack), 0);
    check("rst_romdata",  32'(bus_a.romdata), 0);
    check("rst_ldready",  32'(bus_a.ldready), 0);
    check("rst_init",     32'(bus_a.init), 0);
    check("rst_lderr",    32'(bus_a.lderr), 0);
    check("rst_memaddr",  32'(bus_a.memaddr), 0);
    check("rst_memwdata", 32'(bus_a.memwdata), 0);
    check("rst_memoe",    32'(bus_a.memoe), 0);
    check("rst_memwe",    32'(bus_a.memwe), 0);
    check("rst_b_lderr",  32'(bus_b.lderr), 0);
  endtask

  // Called at posedge+1 with the block idle and init low.
  task automatic read_check(input logic [21:0] addr);
    bus_a.romaddr = addr;
    bus_a.romreq  = 1'b1;
    exp_rd.push_back(rd_model(addr));
    @(posedge clk);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      check("rd_oe", 32'(bus_a.memoe), 1);
      check("rd_addr", 32'(bus_a.memaddr), 32'(addr));
    end
    @(negedge clk);
    check("rd_ack", 32'(bus_a.romack), 1);
    check("rd_oe_off", 32'(bus_a.memoe), 0);
    repeat (3) begin
      @(negedge clk);
      check("rd_no_reack", 32'(bus_a.romack), 0);
    end
    @(posedge clk); #1;
    bus_a.romreq = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ld_start();
    bus_a.ldstart = 1'b1;
    wa_m = '0;
    wb_m = '0;
    eb_m = 1'b0;
    @(posedge clk); #1;
    bus_a.ldstart = 1'b0;
  endtask

  // Offers one byte, waits (bounded) for acceptance; returns in write cycle 2.
  task automatic send(input logic [7:0] d, input bit last);
    int n = 0;
    bus_a.ldvalid = 1'b1;
    bus_a.lddata  = d;
    bus_a.ldlast  = last;
    @(negedge clk);
    while (!bus_a.ldready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!bus_a.ldready) begin
      check("ld_timeout", 32'(bus_a.ldready), 1);
      bus_a.ldvalid = 1'b0;
      bus_a.ldlast  = 1'b0;
      return;
    end
    exp_wr_a.push_back({2'b00, wa_m, d});
    wa_m = wa_m + 1'b1;
    if (!eb_m) exp_wr_b.push_back({20'd0, wb_m, d});
    if (wb_m == 4'hF) eb_m = 1'b1;
    else              wb_m = wb_m + 1'b1;
    @(posedge clk); #1;
    acc_cyc       = cyc;
    bus_a.ldvalid = 1'b0;
    bus_a.ldlast  = 1'b0;
    @(negedge clk);
    check("ld_busy", 32'(bus_a.ldready), 0);
    @(posedge clk); #1;
  endtask

  task automatic finish_last();
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      check("init_hold", 32'(bus_a.init), 1);
    end
    @(negedge clk);
    check("init_fall", 32'(bus_a.init), 0);
    check("b_init_fall", 32'(bus_b.init), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int prev;
    logic [7:0] img[4];
    img[0] = 8'h4E; img[1] = 8'h45; img[2] = 8'h53; img[3] = 8'h1A;
    bus_a.romaddr = '0;
    bus_a.romreq  = 1'b0;
    bus_a.ldstart = 1'b0;
    bus_a.ldvalid = 1'b0;
    bus_a.lddata  = '0;
    bus_a.ldlast  = 1'b0;
    wa_m = '0; wb_m = '0; eb_m = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs();
    rstn = 1'b1;
    @(posedge clk); #1;

    // Plain read with a held request
    read_check(22'h000010);

    // Four-byte image load
    ld_start();
    for (int i = 0; i < 4; i++) begin
      prev = acc_cyc;
      send(img[i], i == 3);
      if (i > 0) check("ld_throughput", acc_cyc - prev, LAT + 1);
    end
    finish_last();
    check("load4_wr_drained", exp_wr_a.size(), 0);
    check("load4_lderr", 32'(bus_a.lderr), 0);

    // Read requested during a load waits for init to fall
    ld_start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    bus_a.romaddr = 22'h30005;
    bus_a.romreq  = 1'b1;
    exp_rd.push_back(rd_model(22'h30005));
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    finish_last();
    n = 0;
    while (!bus_a.romack && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rl_ack_seen", 32'(bus_a.romack), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_a.romreq = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rl_rd_drained", exp_rd.size(), 0);

    // Restart mid-load: the in-flight write completes, next byte goes to 0
    ld_start();
    send(8'hA0, 1'b0);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    ld_start();
    send(8'hB0, 1'b0);
    send(8'hB1, 1'b1);
    finish_last();
    check("restart_wr_drained", exp_wr_a.size(), 0);
    check("restart_lderr", 32'(bus_a.lderr), 0);

    // Overflow on the 4-bit twin: 18 bytes, writes only to 0..15
    ld_start();
    for (int i = 0; i < 18; i++) begin
      send(8'(8'h60 + i), i == 17);
      if (i == 15) check("ovf_lderr_before", 32'(bus_b.lderr), 0);
      if (i == 16) check("ovf_lderr_after", 32'(bus_b.lderr), 1);
    end
    finish_last();
    check("ovf_b_lderr_sticky", 32'(bus_b.lderr), 1);
    check("ovf_a_lderr", 32'(bus_a.lderr), 0);
    check("ovf_a_drained", exp_wr_a.size(), 0);
    check("ovf_b_drained", exp_wr_b.size(), 0);
    ld_start();
    check("ovf_lderr_cleared", 32'(bus_b.lderr), 0);
    check("ovf_init_set", 32'(bus_b.init), 1);
    send(8'h77, 1'b1);
    finish_last();

    // Asynchronous reset in the middle of a read
    bus_a.romaddr = 22'h00002A;
    bus_a.romreq  = 1'b1;
    exp_rd.push_back(rd_model(22'h00002A));
    @(posedge clk);
    @(negedge clk);
    check("mid_rd_oe", 32'(bus_a.memoe), 1);
    #2;
    rstn = 1'b0;
    exp_rd.delete();
    wa_m = '0; wb_m = '0; eb_m = 1'b0;
    #1;
    check_reset_outs();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    read_check(22'h00002A);

    repeat (3) @(posedge clk);
    #1;
    check("end_rd_drained", exp_rd.size(), 0);
    check("end_wr_drained", exp_wr_a.size() + exp_wr_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/romload.md
Name: romload

Overview:
- Owns the single external byte-wide ROM backing memory (SRAM-like, fixed access latency).
- Sequences two uses of that memory port:
  - writes of a cartridge image streamed in by the host loader;
  - reads issued by the PRG/CHR ROM arbiter over its romreq/romack handshake.
- Generates the arbiter's init level, which holds the console in reset while an image is loaded.

Parameters:
LAT, 3, memory access cycles per read or write (LAT >= 1)
AW, 22, memory address width in bits

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
romaddr  in  AW  read byte address from ROM arbiter
romreq  in  1  read request; held high by requester until romack
romdata  out  8  read data, valid in the cycle romack is high
romack  out  1  one-cycle read-complete pulse
ldstart  in  1  one-cycle pulse: begin new image load at address 0
ldvalid  in  1  loader byte valid
lddata  in  8  loader byte
ldlast  in  1  qualifies with ldvalid: final byte of image
ldready  out  1  block accepts loader byte this cycle
init  out  1  high while a load is in progress; drives arbiter init
lderr  out  1  sticky: image exceeded 2^AW bytes
memaddr  out  AW  memory address
memwdata  out  8  memory write data
memrdata  in  8  memory read data, sampled at end of last access cycle
memoe  out  1  memory read strobe
memwe  out  1  memory write strobe

Behaviour:
- Reset (rstn low, asynchronous): state IDLE.
  - Outputs: romack=0, romdata=0, ldready=0, init=0, lderr=0, memaddr=0, memwdata=0, memoe=0, memwe=0.
  - Internal: write address waddr=0, access counter=0.
- All other state changes occur on posedge clk.
- States: IDLE, READ, WRITE, RDONE.
- ldstart:
  - Sets init=1, waddr=0, lderr=0 on the next edge, from any state.
  - An access already in flight completes normally, to its original address.
  - ldstart while init=1 restarts the load from address 0.
- IDLE, evaluated in this order:
  - (a) init=1: ldready=1 unless ldstart is high this cycle; romreq is ignored.
    - On an edge with ldvalid&ldready: latch lddata and ldlast, drive memaddr=waddr, memwdata=lddata, go to WRITE.
  - (b) init=0 and romreq=1: latch memaddr=romaddr, go to READ.
- READ:
  - memoe=1 for exactly LAT cycles.
  - At the edge ending the last cycle: romdata<=memrdata, romack<=1 for one cycle, go to RDONE.
- RDONE: stay until romreq=0, then go to IDLE. This guarantees a held request is never served twice.
- WRITE:
  - memwe=1 for exactly LAT cycles; ldready=0.
  - At the final edge: waddr<=waddr+1, go to IDLE.
  - If the latched ldlast=1: init<=0 at the same edge.
- Read latency: romreq sampled in IDLE at edge t; memoe is high in cycles t+1..t+LAT; romack is high in cycle t+LAT+1.
- Write throughput: one byte per LAT+1 cycles. ldready stays low from the accepting edge until the state returns to IDLE.
- Overflow:
  - When waddr=2^AW-1 completes a write, waddr holds at that value instead of wrapping, and lderr<=1.
  - Further bytes are accepted (ldready handshake unchanged) but memwe stays 0 for them.
  - The load still ends on ldlast.
- Simultaneous events:
  - ldstart and romreq in IDLE: ldstart wins; no read starts.
  - ldlast without ldvalid is ignored.
  - A romreq arriving while init=1 stays pending and is served after init falls.
- memoe and memwe are never high in the same cycle. Both are 0 in IDLE and RDONE.
- memaddr, memwdata, romdata and lderr hold their values when not being updated.

Test Plan:
- Reset, then read: romreq=1, romaddr=0x000010, memrdata=0x4E, LAT=3 → memoe high 3 cycles with memaddr=0x000010; romack high in cycle 4 after the sampling edge with romdata=0x4E; no second ack while romreq is still held.
- Load of 4 bytes 0x4E,0x45,0x53,0x1A after ldstart, ldvalid always high, ldlast on byte 4 → memwe pulses at addresses 0,1,2,3 with matching memwdata; ldready low during each write; init falls at the edge completing address 3.
- Read during load: ldstart, then romreq=1 during byte 2 → no memoe and no romack until init falls; afterwards exactly one read is served.
- ldstart mid-load after 3 bytes written → in-flight write completes; next accepted byte is written at address 0; lderr=0.
- AW=4 overflow: load 18 bytes → memwe for addresses 0..15 only; lderr=1 after the 16th write; bytes 17 and 18 handshake without memwe; init falls on ldlast.
- rstn asserted mid-READ → all outputs 0 immediately; after release with romreq=1, a fresh read is served with full LAT latency.
